// File: rtl/pipe_control_unit.sv
// Pipelined, condition-aware control unit: decodes one instruction per cycle and
// carries its controls through EX, MEM and WB against an internal NZCV register.
module pipe_control_unit #(
   parameter int REG_ADDR_W = 4,
   parameter bit COND_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   input  logic [31:0]           instr,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [3:0]            alu_nzcv,
   output logic                  ex_valid,
   output logic [1:0]            ex_alu_op,
   output logic                  ex_alu_imm,
   output logic                  ex_is_ls,
   output logic                  ex_is_branch,
   output logic                  branch_taken,
   output logic                  mem_valid,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [3:0]            flags,
   output logic                  illegal
);

   typedef struct packed {
      logic [3:0]            cond;
      logic [1:0]            alu_op;
      logic                  alu_imm;
      logic                  is_alu;
      logic                  is_ls;
      logic                  is_branch;
      logic                  set_flags;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } ctrl_t;

   ctrl_t                 dec_ctrl;
   logic                  dec_illegal;
   ctrl_t                 ex_q;
   logic                  ex_occ;
   logic                  cond_pass;
   logic                  mem_reg_write;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  unused_instr;

   assign unused_instr = ^instr;

   always_comb begin
      dec_ctrl      = '0;
      dec_illegal   = 1'b0;
      dec_ctrl.cond = instr[31:28];
      dec_ctrl.rd   = instr[12 +: REG_ADDR_W];
      case (instr[27:26])
         2'b00: begin
            dec_ctrl.is_alu    = 1'b1;
            dec_ctrl.alu_imm   = instr[25];
            dec_ctrl.set_flags = instr[20];
            dec_ctrl.reg_write = 1'b1;
            case (instr[24:21])
               4'b0100: dec_ctrl.alu_op = 2'b10;
               4'b0010: dec_ctrl.alu_op = 2'b11;
               4'b0000: dec_ctrl.alu_op = 2'b00;
               4'b1100: dec_ctrl.alu_op = 2'b01;
               default: dec_illegal     = 1'b1;
            endcase
         end
         2'b01: begin
            dec_ctrl.is_ls     = 1'b1;
            dec_ctrl.alu_op    = 2'b10;
            dec_ctrl.alu_imm   = instr[25];
            dec_ctrl.mem_read  = instr[20];
            dec_ctrl.mem_write = ~instr[20];
            dec_ctrl.reg_write = instr[20];
         end
         2'b10:   dec_ctrl.is_branch = 1'b1;
         default: dec_illegal = 1'b1;
      endcase
      if (COND_EN && instr[31:28] == 4'hF) dec_illegal = 1'b1;
   end

   // Condition check uses the committed flags; the previous setter has already written them.
   always_comb begin
      cond_pass = 1'b1;
      if (COND_EN) begin
         case (ex_q.cond)
            4'h0:    cond_pass = flags[2];
            4'h1:    cond_pass = ~flags[2];
            4'h2:    cond_pass = flags[1];
            4'h3:    cond_pass = ~flags[1];
            4'h4:    cond_pass = flags[3];
            4'h5:    cond_pass = ~flags[3];
            4'h6:    cond_pass = flags[0];
            4'h7:    cond_pass = ~flags[0];
            4'h8:    cond_pass = flags[1] & ~flags[2];
            4'h9:    cond_pass = ~flags[1] | flags[2];
            4'hA:    cond_pass = (flags[3] == flags[0]);
            4'hB:    cond_pass = (flags[3] != flags[0]);
            4'hC:    cond_pass = ~flags[2] & (flags[3] == flags[0]);
            4'hD:    cond_pass = flags[2] | (flags[3] != flags[0]);
            default: cond_pass = 1'b1;
         endcase
      end
   end

   assign ex_valid     = ex_occ & cond_pass;
   assign ex_alu_op    = ex_q.alu_op;
   assign ex_alu_imm   = ex_q.alu_imm;
   assign ex_is_ls     = ex_q.is_ls;
   assign ex_is_branch = ex_q.is_branch;
   assign branch_taken = ex_valid & ex_q.is_branch & ~stall;

   // Flush beats stall for EX; a taken branch squashes whatever is being captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_occ  <= 1'b0;
         ex_q    <= '0;
         illegal <= 1'b0;
      end else if (flush || (!stall && branch_taken)) begin
         ex_occ  <= 1'b0;
         ex_q    <= '0;
         illegal <= 1'b0;
      end else if (!stall) begin
         ex_occ  <= instr_valid & ~dec_illegal;
         ex_q    <= (instr_valid && !dec_illegal) ? dec_ctrl : '0;
         illegal <= instr_valid & dec_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid     <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_reg_write <= 1'b0;
         mem_rd        <= '0;
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_rd         <= '0;
         flags         <= 4'b0000;
      end else if (!stall) begin
         if (ex_valid && !flush) begin
            mem_valid     <= 1'b1;
            mem_read      <= ex_q.mem_read;
            mem_write     <= ex_q.mem_write;
            mem_reg_write <= ex_q.reg_write;
            mem_rd        <= ex_q.rd;
         end else begin
            mem_valid     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
         end
         wb_valid     <= mem_valid;
         wb_reg_write <= mem_reg_write;
         wb_rd        <= mem_rd;
         if (ex_valid && !flush && ex_q.is_alu && ex_q.set_flags) flags <= alu_nzcv;
      end
   end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed testbench for pipe_control_unit: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_pipe_control_unit;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        stall;
   logic        flush;
   logic [3:0]  alu_nzcv;
   logic        ex_valid;
   logic [1:0]  ex_alu_op;
   logic        ex_alu_imm;
   logic        ex_is_ls;
   logic        ex_is_branch;
   logic        branch_taken;
   logic        mem_valid;
   logic        mem_read;
   logic        mem_write;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [3:0]  wb_rd;
   logic [3:0]  flags;
   logic        illegal;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [31:0] ADDS_R3 = 32'hE0903000;
   localparam logic [31:0] ADD_R3  = 32'hE0803000;
   localparam logic [31:0] SUBS_R0 = 32'hE0500000;
   localparam logic [31:0] BEQ     = 32'h08000000;
   localparam logic [31:0] LDR_R2  = 32'hE6102000;
   localparam logic [31:0] STR_R2  = 32'hE6002000;
   localparam logic [31:0] ILL_OP  = 32'hE0200000;
   localparam logic [31:0] ILL_NV  = 32'hF0903000;

   pipe_control_unit #(.REG_ADDR_W(4), .COND_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .stall(stall), .flush(flush), .alu_nzcv(alu_nzcv),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_imm(ex_alu_imm),
      .ex_is_ls(ex_is_ls), .ex_is_branch(ex_is_branch), .branch_taken(branch_taken),
      .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .flags(flags), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0; alu_nzcv = '0;
      #3;
      n_vec++; if (ex_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL reset_ex_valid got %b expected 0", ex_valid); end
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL reset_mem_valid got %b expected 0", mem_valid); end
      n_vec++; if (flags !== 4'b0000)     begin n_err++; $display("[TB] FAIL reset_flags got %b expected 0000", flags); end
      n_vec++; if (illegal !== 1'b0)      begin n_err++; $display("[TB] FAIL reset_illegal got %b expected 0", illegal); end
      #9 rst_n = 1'b1;
      tick();
      n_vec++; if (wb_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL reset_wb_valid got %b expected 0", wb_valid); end
   endtask

   task automatic test_latency();
      instr = ADDS_R3; instr_valid = 1'b1; alu_nzcv = 4'b0100;
      tick();
      instr_valid = 1'b0;
      n_vec++; if (ex_valid !== 1'b1)     begin n_err++; $display("[TB] FAIL lat_ex_valid got %b expected 1", ex_valid); end
      n_vec++; if (ex_alu_op !== 2'b10)   begin n_err++; $display("[TB] FAIL lat_ex_alu_op got %b expected 10", ex_alu_op); end
      n_vec++; if (flags !== 4'b0000)     begin n_err++; $display("[TB] FAIL lat_flags_early got %b expected 0000", flags); end
      tick();
      n_vec++; if (mem_valid !== 1'b1)    begin n_err++; $display("[TB] FAIL lat_mem_valid got %b expected 1", mem_valid); end
      n_vec++; if (flags !== 4'b0100)     begin n_err++; $display("[TB] FAIL flag_set got %b expected 0100", flags); end
      tick();
      n_vec++; if (wb_reg_write !== 1'b1) begin n_err++; $display("[TB] FAIL lat_wb_reg_write got %b expected 1", wb_reg_write); end
      n_vec++; if (wb_rd !== 4'd3)        begin n_err++; $display("[TB] FAIL lat_wb_rd got %0d expected 3", wb_rd); end
   endtask

   task automatic test_cond_branch();
      instr = ADDS_R3; instr_valid = 1'b1; alu_nzcv = 4'b0100;
      tick();
      instr = SUBS_R0;
      tick();
      instr = BEQ; alu_nzcv = 4'b0000;
      tick();
      n_vec++; if (flags !== 4'b0000)     begin n_err++; $display("[TB] FAIL cond_flags got %b expected 0000", flags); end
      n_vec++; if (ex_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL cond_ex_valid got %b expected 0", ex_valid); end
      n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("[TB] FAIL cond_branch_taken got %b expected 0", branch_taken); end
      instr_valid = 1'b0;
      tick();
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL cond_mem_bubble got %b expected 0", mem_valid); end
   endtask

   task automatic test_taken_branch();
      instr = ADDS_R3; instr_valid = 1'b1; alu_nzcv = 4'b0100;
      tick();
      instr = BEQ;
      tick();
      n_vec++; if (flags !== 4'b0100)     begin n_err++; $display("[TB] FAIL tb_flags got %b expected 0100", flags); end
      n_vec++; if (ex_is_branch !== 1'b1) begin n_err++; $display("[TB] FAIL tb_ex_is_branch got %b expected 1", ex_is_branch); end
      n_vec++; if (branch_taken !== 1'b1) begin n_err++; $display("[TB] FAIL tb_branch_taken got %b expected 1", branch_taken); end
      instr = ADDS_R3; alu_nzcv = 4'b0000;
      tick();
      n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("[TB] FAIL tb_taken_pulse got %b expected 0", branch_taken); end
      n_vec++; if (ex_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL tb_squash_ex got %b expected 0", ex_valid); end
      n_vec++; if (mem_valid !== 1'b1)    begin n_err++; $display("[TB] FAIL tb_branch_mem_valid got %b expected 1", mem_valid); end
      n_vec++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("[TB] FAIL tb_branch_mem_ctrl got %b expected 00", {mem_read, mem_write}); end
      instr_valid = 1'b0;
      tick();
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL tb_squash_mem got %b expected 0", mem_valid); end
      n_vec++; if (wb_valid !== 1'b1)     begin n_err++; $display("[TB] FAIL tb_branch_wb_valid got %b expected 1", wb_valid); end
      n_vec++; if (wb_reg_write !== 1'b0) begin n_err++; $display("[TB] FAIL tb_branch_wb_write got %b expected 0", wb_reg_write); end
      tick();
      n_vec++; if (wb_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL tb_squash_wb got %b expected 0", wb_valid); end
   endtask

   task automatic test_load_store();
      instr = LDR_R2; instr_valid = 1'b1;
      tick();
      n_vec++; if (ex_is_ls !== 1'b1)     begin n_err++; $display("[TB] FAIL ld_ex_is_ls got %b expected 1", ex_is_ls); end
      n_vec++; if (ex_alu_imm !== 1'b1)   begin n_err++; $display("[TB] FAIL ld_ex_alu_imm got %b expected 1", ex_alu_imm); end
      n_vec++; if (ex_alu_op !== 2'b10)   begin n_err++; $display("[TB] FAIL ld_ex_alu_op got %b expected 10", ex_alu_op); end
      instr = STR_R2;
      tick();
      n_vec++; if (mem_read !== 1'b1)     begin n_err++; $display("[TB] FAIL ld_mem_read got %b expected 1", mem_read); end
      instr_valid = 1'b0;
      tick();
      n_vec++; if (mem_write !== 1'b1)    begin n_err++; $display("[TB] FAIL st_mem_write got %b expected 1", mem_write); end
      n_vec++; if (mem_read !== 1'b0)     begin n_err++; $display("[TB] FAIL st_mem_read got %b expected 0", mem_read); end
      n_vec++; if (wb_rd !== 4'd2)        begin n_err++; $display("[TB] FAIL ld_wb_rd got %0d expected 2", wb_rd); end
      n_vec++; if (wb_reg_write !== 1'b1) begin n_err++; $display("[TB] FAIL ld_wb_reg_write got %b expected 1", wb_reg_write); end
      tick();
      n_vec++; if ({wb_valid, wb_reg_write} !== 2'b10) begin n_err++; $display("[TB] FAIL st_wb got %b expected 10", {wb_valid, wb_reg_write}); end
   endtask

   task automatic test_stall();
      instr = ADD_R3; instr_valid = 1'b1;
      tick();
      stall = 1'b1; instr = LDR_R2; alu_nzcv = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++; if (ex_valid !== 1'b1)     begin n_err++; $display("[TB] FAIL stall_ex_valid[%0d] got %b expected 1", i, ex_valid); end
         n_vec++; if (ex_is_ls !== 1'b0)     begin n_err++; $display("[TB] FAIL stall_no_capture[%0d] got %b expected 0", i, ex_is_ls); end
         n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL stall_mem_hold[%0d] got %b expected 0", i, mem_valid); end
         n_vec++; if (flags !== 4'b0100)     begin n_err++; $display("[TB] FAIL stall_flags[%0d] got %b expected 0100", i, flags); end
         n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("[TB] FAIL stall_branch_taken[%0d] got %b expected 0", i, branch_taken); end
      end
      stall = 1'b0; instr_valid = 1'b0; alu_nzcv = 4'b0000;
      tick();
      n_vec++; if (mem_valid !== 1'b1)    begin n_err++; $display("[TB] FAIL stall_mem_late got %b expected 1", mem_valid); end
      n_vec++; if (ex_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL stall_ex_after got %b expected 0", ex_valid); end
      tick();
      n_vec++; if (wb_rd !== 4'd3)        begin n_err++; $display("[TB] FAIL stall_wb_rd got %0d expected 3", wb_rd); end
   endtask

   task automatic test_illegal();
      instr = ILL_OP; instr_valid = 1'b1;
      tick();
      n_vec++; if (illegal !== 1'b1)      begin n_err++; $display("[TB] FAIL ill_op_pulse got %b expected 1", illegal); end
      n_vec++; if (ex_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL ill_ex_valid got %b expected 0", ex_valid); end
      instr = ILL_NV;
      tick();
      n_vec++; if (illegal !== 1'b1)      begin n_err++; $display("[TB] FAIL ill_nv_pulse got %b expected 1", illegal); end
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL ill_mem_bubble got %b expected 0", mem_valid); end
      instr_valid = 1'b0;
      tick();
      n_vec++; if (illegal !== 1'b0)      begin n_err++; $display("[TB] FAIL ill_bubble_quiet got %b expected 0", illegal); end
   endtask

   task automatic test_flush();
      instr = LDR_R2; instr_valid = 1'b1;
      tick();
      instr = ADD_R3;
      tick();
      stall = 1'b1; flush = 1'b1; instr_valid = 1'b0;
      tick();
      n_vec++; if (ex_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL flush_ex_valid got %b expected 0", ex_valid); end
      n_vec++; if ({mem_valid, mem_read} !== 2'b11) begin n_err++; $display("[TB] FAIL flush_mem_hold got %b expected 11", {mem_valid, mem_read}); end
      n_vec++; if (wb_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL flush_wb_hold got %b expected 0", wb_valid); end
      stall = 1'b0; flush = 1'b0;
      tick();
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL flush_mem_bubble got %b expected 0", mem_valid); end
      n_vec++; if (wb_rd !== 4'd2)        begin n_err++; $display("[TB] FAIL flush_wb_rd got %0d expected 2", wb_rd); end
      tick();
      n_vec++; if (wb_valid !== 1'b0)     begin n_err++; $display("[TB] FAIL flush_wb_bubble got %b expected 0", wb_valid); end
   endtask

   task automatic test_reset_midstream();
      instr = ADDS_R3; instr_valid = 1'b1; alu_nzcv = 4'b0010;
      tick();
      instr_valid = 1'b0;
      tick();
      n_vec++; if (flags !== 4'b0010)     begin n_err++; $display("[TB] FAIL mid_flags_before got %b expected 0010", flags); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (flags !== 4'b0000)     begin n_err++; $display("[TB] FAIL mid_async_flags got %b expected 0000", flags); end
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL mid_async_mem got %b expected 0", mem_valid); end
      n_vec++; if ({wb_valid, wb_reg_write, wb_rd} !== 6'b0) begin n_err++; $display("[TB] FAIL mid_async_wb got %b expected 0", {wb_valid, wb_reg_write, wb_rd}); end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      n_vec++; if (flags !== 4'b0000)     begin n_err++; $display("[TB] FAIL mid_flags_after got %b expected 0000", flags); end
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("[TB] FAIL mid_mem_after got %b expected 0", mem_valid); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_cond_branch();
      test_taken_branch();
      test_load_store();
      test_stall();
      test_illegal();
      test_flush();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
